ir_tcu_sequencer: RTL and testbench

- Instruction-register and timing-control stage that sits directly upstream of the 6502 control decoder.
- Holds the current opcode (IR) and timing state (TCU) that drive the decoder.
- Registers the decoder's next-TCU value, latches the fetched opcode from the data bus at the end of T0, and injects BRK (0x00) for RESET, NMI and IRQ.
- Applies RDY stalls and flags a runaway TCU.

---
 rtl/ir_tcu_sequencer.sv | 118 +++++++++++
 tb/tb_ir_tcu_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ir_tcu_sequencer.sv
// Instruction register and timing-control unit ahead of the 6502 control decoder.
// It latches opcodes at fetch end, injects BRK for reset/NMI/IRQ, applies RDY stalls and traps a runaway TCU.
module ir_tcu_sequencer #(
    parameter logic [3:0] MAX_TCU    = 4'd7,
    parameter logic [3:0] RESET_TCU  = 4'd1,
    parameter logic [7:0] BRK_OPCODE = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [7:0] i_data,
    input  logic [3:0] i_tcu_next,
    input  logic       i_rw,
    input  logic       i_rdy,
    input  logic       i_nmi_n,
    input  logic       i_irq_n,
    input  logic       i_irq_mask,
    output logic [7:0] o_ir,
    output logic [3:0] o_tcu,
    output logic       o_sync,
    output logic [1:0] o_int_type,
    output logic       o_int_active,
    output logic       o_tcu_overflow
);

    typedef enum logic [1:0] {
        INT_NONE  = 2'd0,
        INT_IRQ   = 2'd1,
        INT_NMI   = 2'd2,
        INT_RESET = 2'd3
    } int_type_e;

    logic [7:0] ir_q, ir_d;
    logic [3:0] tcu_q, tcu_d;
    int_type_e  int_type_q, int_type_d;
    logic       int_active_q, int_active_d;
    logic       overflow_q, overflow_d;
    logic       nmi_prev_q;
    logic       nmi_pending_q, nmi_pending_d;

    logic stall;
    logic fetch_end;
    logic nmi_edge;
    logic irq_req;

    // Only read cycles can be stretched by RDY; writes always complete.
    assign stall     = ~i_rdy & i_rw;
    assign fetch_end = ~stall & (tcu_q == 4'd0);
    assign nmi_edge  = nmi_prev_q & ~i_nmi_n;
    assign irq_req   = ~i_irq_n & ~i_irq_mask;

    always_comb begin
        ir_d          = ir_q;
        tcu_d         = tcu_q;
        int_type_d    = int_type_q;
        int_active_d  = int_active_q;
        overflow_d    = overflow_q;
        nmi_pending_d = nmi_pending_q;

        if (!stall) begin
            if (i_tcu_next > MAX_TCU) begin
                tcu_d      = 4'd0;
                overflow_d = 1'b1;
            end else begin
                tcu_d = i_tcu_next;
            end
        end

        // Priority uses the registered pending flag, so an edge seen on this very clock waits for the next fetch.
        if (fetch_end) begin
            if (nmi_pending_q) begin
                ir_d          = BRK_OPCODE;
                int_type_d    = INT_NMI;
                int_active_d  = 1'b1;
                nmi_pending_d = 1'b0;
            end else if (irq_req) begin
                ir_d         = BRK_OPCODE;
                int_type_d   = INT_IRQ;
                int_active_d = 1'b1;
            end else begin
                ir_d         = i_data;
                int_type_d   = INT_NONE;
                int_active_d = 1'b0;
            end
        end

        if (nmi_edge) begin
            nmi_pending_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ir_q          <= BRK_OPCODE;
            tcu_q         <= RESET_TCU;
            int_type_q    <= INT_RESET;
            int_active_q  <= 1'b1;
            overflow_q    <= 1'b0;
            nmi_prev_q    <= 1'b1;
            nmi_pending_q <= 1'b0;
        end else begin
            ir_q          <= ir_d;
            tcu_q         <= tcu_d;
            int_type_q    <= int_type_d;
            int_active_q  <= int_active_d;
            overflow_q    <= overflow_d;
            nmi_prev_q    <= i_nmi_n;
            nmi_pending_q <= nmi_pending_d;
        end
    end

    assign o_ir           = ir_q;
    assign o_tcu          = tcu_q;
    assign o_sync         = (tcu_q == 4'd0);
    assign o_int_type     = int_type_q;
    assign o_int_active   = int_active_q;
    assign o_tcu_overflow = overflow_q;

endmodule

// File: tb/tb_ir_tcu_sequencer.sv
// Directed bench for ir_tcu_sequencer: reset, fetch, RDY stalls, NMI/IRQ injection and TCU overflow trapping.
module tb_ir_tcu_sequencer;

    logic       clk;
    logic       reset_n;
    logic [7:0] data;
    logic [3:0] tcu_next;
    logic       rw;
    logic       rdy;
    logic       nmi_n;
    logic       irq_n;
    logic       irq_mask;
    logic [7:0] o_ir;
    logic [3:0] o_tcu;
    logic       o_sync;
    logic [1:0] o_int_type;
    logic       o_int_active;
    logic       o_tcu_overflow;

    int checks = 0;
    int errors = 0;

    ir_tcu_sequencer dut (
        .i_clk          (clk),
        .i_reset_n      (reset_n),
        .i_data         (data),
        .i_tcu_next     (tcu_next),
        .i_rw           (rw),
        .i_rdy          (rdy),
        .i_nmi_n        (nmi_n),
        .i_irq_n        (irq_n),
        .i_irq_mask     (irq_mask),
        .o_ir           (o_ir),
        .o_tcu          (o_tcu),
        .o_sync         (o_sync),
        .o_int_type     (o_int_type),
        .o_int_active   (o_int_active),
        .o_tcu_overflow (o_tcu_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst_n, input logic [7:0] d, input logic [3:0] nxt,
                                 input logic w_rw, input logic w_rdy, input logic w_nmi_n,
                                 input logic w_irq_n, input logic w_mask);
        reset_n  = rst_n;
        data     = d;
        tcu_next = nxt;
        rw       = w_rw;
        rdy      = w_rdy;
        nmi_n    = w_nmi_n;
        irq_n    = w_irq_n;
        irq_mask = w_mask;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkState(input string step, input logic [7:0] ir, input logic [3:0] tcu,
                              input logic [1:0] itype, input logic active, input logic ovf);
        logic exp_sync;
        exp_sync = (tcu == 4'h0);
        checkOutput({step, " ir"},       o_ir,                      ir);
        checkOutput({step, " tcu"},      {4'h0, o_tcu},             {4'h0, tcu});
        checkOutput({step, " sync"},     {7'h0, o_sync},            {7'h0, exp_sync});
        checkOutput({step, " int_type"}, {6'h0, o_int_type},        {6'h0, itype});
        checkOutput({step, " active"},   {7'h0, o_int_active},      {7'h0, active});
        checkOutput({step, " overflow"}, {7'h0, o_tcu_overflow},    {7'h0, ovf});
    endtask

    initial begin
        $display("[TB] ir_tcu_sequencer directed test start");

        // Power-on reset, then run the reset BRK down to a fetch of 0xAD and into its T3.
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("por", 8'h00, 4'd1, 2'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("brk_to_t0", 8'h00, 4'd0, 2'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hAD, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("fetch_ad", 8'hAD, 4'd1, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("mid_instr", 8'hAD, 4'd3, 2'd0, 1'b0, 1'b0);

        // Mid-instruction reset held for three clocks, then released.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'hAD, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            checkState("rst_hold", 8'h00, 4'd1, 2'd3, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 8'h00, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("rst_release", 8'h00, 4'd2, 2'd3, 1'b1, 1'b0);

        // T0: IR still shows the previous opcode; the fetched opcode appears one clock later.
        applyStimulus(1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("t0_hold_ir", 8'h00, 4'd0, 2'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hA9, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("fetch_a9", 8'hA9, 4'd1, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("to_t2", 8'hA9, 4'd2, 2'd0, 1'b0, 1'b0);

        // Read stall holds everything; a write cycle ignores RDY.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'h00, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
            checkState("stall_read", 8'hA9, 4'd2, 2'd0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 8'h00, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkState("write_no_stall", 8'hA9, 4'd3, 2'd0, 1'b0, 1'b0);

        // NMI falling edge with an unmasked IRQ also pending: NMI first, IRQ at the next fetch end.
        applyStimulus(1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkState("nmi_edge", 8'hA9, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hEA, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkState("nmi_serviced", 8'h00, 4'd1, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkState("nmi_to_t0", 8'h00, 4'd0, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hEA, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkState("irq_serviced", 8'h00, 4'd1, 2'd1, 1'b1, 1'b0);

        // Masked IRQ lets the fetched opcode through.
        applyStimulus(1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hEA, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        checkState("irq_masked", 8'hEA, 4'd1, 2'd0, 1'b0, 1'b0);

        // NMI edge on the fetch-end clock itself is deferred to the following fetch end.
        applyStimulus(1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h18, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checkState("nmi_late", 8'h18, 4'd1, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'hEA, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        checkState("nmi_deferred", 8'h00, 4'd1, 2'd2, 1'b1, 1'b0);

        // Fetched 0x00 is a software BRK: no interrupt type, not injected.
        applyStimulus(1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 8'h00, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("sw_brk", 8'h00, 4'd1, 2'd0, 1'b0, 1'b0);

        // Runaway TCU: trapped to 0, flag sticky until reset.
        applyStimulus(1'b1, 8'h00, 4'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("tcu_max", 8'h00, 4'd7, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h00, 4'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("overflow", 8'h00, 4'd0, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'hA9, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("ovf_sticky", 8'hA9, 4'd1, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("ovf_sticky2", 8'hA9, 4'd0, 2'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("ovf_reset", 8'h00, 4'd1, 2'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h00, 4'd15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("overflow_15", 8'h00, 4'd0, 2'd3, 1'b1, 1'b1);
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkState("final_reset", 8'h00, 4'd1, 2'd3, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
